// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controllers: buffer occupancy encoding,
// pointer-width helper and the memory-level computation.
package fifo_pkg;

  // Widest pointer the level helper handles; pointers are zero-extended into it.
  localparam int FIFO_PTR_MAX_W = 32;

  // Output-buffer occupancy; the encoding equals the number of words held.
  typedef enum logic [1:0] {
    OCC_B0 = 2'd0,
    OCC_B1 = 2'd1,
    OCC_B2 = 2'd2
  } occ_t;

  // Pointers carry one wrap bit above the address bits.
  function automatic int fifo_ptr_w(input int aw);
    return aw + 1;
  endfunction

  // Words between read and write pointer, modulo 2^ptr_w.
  function automatic logic [FIFO_PTR_MAX_W-1:0] fifo_level(
    input logic [FIFO_PTR_MAX_W-1:0] wr_ptr,
    input logic [FIFO_PTR_MAX_W-1:0] rd_ptr,
    input int                        ptr_w
  );
    logic [FIFO_PTR_MAX_W-1:0] mask;
    mask = (FIFO_PTR_MAX_W'(1) << ptr_w) - FIFO_PTR_MAX_W'(1);
    return (wr_ptr - rd_ptr) & mask;
  endfunction

  // Number of words buffered for a given occupancy state.
  function automatic logic [1:0] occ_words(input occ_t s);
    logic [1:0] n;
    case (s)
      OCC_B1:  n = 2'd1;
      OCC_B2:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry head/skid output buffer for the FIFO read controller.
// Head always holds the oldest word; skid catches a fetch made while the
// consumer stalls so one word per cycle is sustained with registered outputs.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          I_CLK,
  input  logic          I_RST_N,
  input  logic          I_FETCH,
  input  logic [DW-1:0] I_FETCH_DATA,
  input  logic          I_READY,
  output logic          O_VALID,
  output logic [DW-1:0] O_DATA,
  output occ_t          O_STATE
);

  occ_t          state_q, state_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] head_q, skid_q;
  logic          pop;
  logic          head_ld, head_from_skid, skid_ld;

  // Next occupancy and buffer load controls; unused encodings fall back to empty.
  always_comb begin
    pop            = valid_q & I_READY;
    state_d        = state_q;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    case (state_q)
      OCC_B0: begin
        if (I_FETCH) begin
          head_ld = 1'b1;
          state_d = OCC_B1;
        end
      end
      OCC_B1: begin
        case ({I_FETCH, pop})
          2'b10: begin
            skid_ld = 1'b1;
            state_d = OCC_B2;
          end
          2'b01: state_d = OCC_B0;
          2'b11: head_ld = 1'b1;
          default: ;
        endcase
      end
      OCC_B2: begin
        if (pop) begin
          head_ld        = 1'b1;
          head_from_skid = 1'b1;
          if (I_FETCH) skid_ld = 1'b1;
          else         state_d = OCC_B1;
        end
      end
      default: state_d = OCC_B0;
    endcase
    valid_d = (state_d != OCC_B0);
  end

  // Occupancy, valid flag and the two data slots.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= OCC_B0;
      valid_q <= 1'b0;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (head_ld) head_q <= head_from_skid ? skid_q : I_FETCH_DATA;
      if (skid_ld) skid_q <= I_FETCH_DATA;
    end
  end

  assign O_VALID = valid_q;
  assign O_DATA  = head_q;
  assign O_STATE = state_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: owns the read pointer, addresses the memory's
// asynchronous read port and feeds a registered valid/ready stream through
// a 2-entry output buffer.
// Optional feature macro: FIFO_RD_ALMOST_EMPTY_EN adds O_ALMOST_EMPTY and
// the AE_THRESH parameter.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  parameter int AE_THRESH = 2
`endif
) (
  input  logic        I_CLK,
  input  logic        I_RST_N,
  input  logic [AW:0] I_WR_PTR,
  output logic [AW:0] O_RD_PTR,
  output logic [AW-1:0] O_RD_ADDR,
  input  logic [DW-1:0] I_RD_DATA,
  output logic        O_VALID,
  input  logic        I_READY,
  output logic [DW-1:0] O_DATA,
  output logic        O_EMPTY
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  output logic        O_ALMOST_EMPTY
`endif
);

  localparam int PW = fifo_ptr_w(AW);

  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] level;
  logic          mem_empty;
  logic          pop;
  logic          fetch;
  occ_t          occ;

  assign level     = PW'(fifo_level(FIFO_PTR_MAX_W'(I_WR_PTR), FIFO_PTR_MAX_W'(rd_ptr_q), PW));
  assign mem_empty = (level == '0);
  assign pop       = O_VALID & I_READY;
  // A word is pulled whenever memory has one and the buffer has room after this cycle's pop.
  assign fetch     = ~mem_empty & ((occ != OCC_B2) | pop);

  // Read pointer advances on every fetch; wrap bit flips as the address wraps.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) rd_ptr_q <= '0;
    else if (fetch) rd_ptr_q <= rd_ptr_q + PW'(1);
  end

  assign O_RD_PTR  = rd_ptr_q;
  assign O_RD_ADDR = rd_ptr_q[AW-1:0];

  fifo_rd_skid #(
    .DW (DW)
  ) u_skid (
    .I_CLK        (I_CLK),
    .I_RST_N      (I_RST_N),
    .I_FETCH      (fetch),
    .I_FETCH_DATA (I_RD_DATA),
    .I_READY      (I_READY),
    .O_VALID      (O_VALID),
    .O_DATA       (O_DATA),
    .O_STATE      (occ)
  );

  assign O_EMPTY = (occ == OCC_B0) & mem_empty;

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic [PW:0] ae_total;
  // Words still to be delivered: memory level plus buffered words.
  always_comb begin
    ae_total       = {1'b0, level} + (PW+1)'(occ_words(occ));
    O_ALMOST_EMPTY = (ae_total <= (PW+1)'(AE_THRESH));
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed testbench for fifo_rd_ctrl (DW=32, AW=4) with a behavioural
// 16-word memory and write pointer driven by the bench.
module tb_fifo_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  wr_ptr = '0;
  logic [4:0]  rd_ptr;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        ready = 1'b0;
  logic        valid;
  logic [31:0] data;
  logic        empty;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic        ae;
`endif

  logic [31:0] mem [16];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign rd_data = mem[rd_addr];

  fifo_rd_ctrl #(.DW(32), .AW(4)) dut (
    .I_CLK     (clk),
    .I_RST_N   (rst_n),
    .I_WR_PTR  (wr_ptr),
    .O_RD_PTR  (rd_ptr),
    .O_RD_ADDR (rd_addr),
    .I_RD_DATA (rd_data),
    .O_VALID   (valid),
    .I_READY   (ready),
    .O_DATA    (data),
    .O_EMPTY   (empty)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    .O_ALMOST_EMPTY (ae)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    mem[wr_ptr[3:0]] = d;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    wr_ptr = '0;
    ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 + i;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    #2;
    rst_n = 1'b0;
    wr_ptr = '0;
    #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (rd_ptr !== 5'd0) begin bad++; $display("FAIL reset_rd_ptr got=%0d want=0", rd_ptr); end
    total++; if (data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", data); end
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    total++; if (ae !== 1'b1) begin bad++; $display("FAIL reset_ae got=%b want=1", ae); end
`endif
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset;
    ready = 1'b1;
    push(32'hA5);
    #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", valid); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_not_empty got=%b want=0", empty); end
    tick;
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", valid); end
    total++; if (data !== 32'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", data); end
    total++; if (rd_ptr !== 5'd1) begin bad++; $display("FAIL single_rd_ptr got=%0d want=1", rd_ptr); end
    total++; if (rd_addr !== 4'd1) begin bad++; $display("FAIL single_rd_addr got=%0d want=1", rd_addr); end
    tick;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_after_pop_valid got=%b want=0", valid); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_after_pop_empty got=%b want=1", empty); end
  endtask

  task automatic test_fill;
    do_reset;
    for (int i = 0; i < 16; i++) begin
      tick;
      push(32'(i));
    end
    tick;
    tick;
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL fill_valid got=%b want=1", valid); end
    total++; if (data !== 32'd0) begin bad++; $display("FAIL fill_data got=%h want=0", data); end
    total++; if (rd_ptr !== 5'd2) begin bad++; $display("FAIL fill_rd_ptr got=%0d want=2", rd_ptr); end
    total++; if (rd_addr !== 4'd2) begin bad++; $display("FAIL fill_rd_addr got=%0d want=2", rd_addr); end
    tick;
    total++; if (data !== 32'd0) begin bad++; $display("FAIL fill_stall_data got=%h want=0", data); end
    ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      total++;
      if (valid !== 1'b1 || data !== 32'(k)) begin
        bad++;
        $display("FAIL fill_drain idx=%0d got valid=%b data=%h want valid=1 data=%h", k, valid, data, 32'(k));
      end
      tick;
    end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL fill_drained_valid got=%b want=0", valid); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_drained_empty got=%b want=1", empty); end
    total++; if (rd_ptr !== 5'd16) begin bad++; $display("FAIL fill_drained_rd_ptr got=%0d want=16", rd_ptr); end
  endtask

  task automatic test_stream;
    do_reset;
    ready = 1'b1;
    for (int c = 0; c < 43; c++) begin
      if (c >= 1 && c <= 40) begin
        total++;
        if (valid !== 1'b1 || data !== 32'(100 + c - 1) || rd_ptr !== 5'(c)) begin
          bad++;
          $display("FAIL stream cyc=%0d got valid=%b data=%0d rd_ptr=%0d want valid=1 data=%0d rd_ptr=%0d",
                   c, valid, data, rd_ptr, 100 + c - 1, c % 32);
        end
      end else begin
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL stream_idle cyc=%0d got valid=%b want=0", c, valid); end
      end
      if (c < 40) push(32'(100 + c));
      tick;
    end
  endtask

  task automatic test_random;
    logic [31:0] q[$];
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [4:0]  lvl;
    int pushed;
    int popped;
    int cyc;
    pushed = 0;
    popped = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    do_reset;
    while (popped < 200 && cyc < 5000) begin
      if (prev_stall) begin
        total++;
        if (valid !== 1'b1 || data !== prev_data) begin
          bad++;
          $display("FAIL rand_stall cyc=%0d got valid=%b data=%h want valid=1 data=%h", cyc, valid, data, prev_data);
        end
      end
      if (valid === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rand_extra cyc=%0d got data=%h want no word", cyc, data);
        end else if (data !== q[0]) begin
          bad++;
          $display("FAIL rand_order cyc=%0d got data=%h want=%h", cyc, data, q[0]);
        end
      end
      ready = 1'($urandom_range(0, 1));
      prev_stall = valid & ~ready;
      prev_data = data;
      if (valid === 1'b1 && ready && q.size() != 0) begin
        void'(q.pop_front());
        popped++;
      end
      lvl = wr_ptr - rd_ptr;
      if (pushed < 200 && lvl < 5'd16 && $urandom_range(0, 2) != 0) begin
        push(32'h1000 + 32'(pushed));
        q.push_back(32'h1000 + 32'(pushed));
        pushed++;
      end
      tick;
      cyc++;
    end
    total++; if (popped != 200) begin bad++; $display("FAIL rand_count got=%0d want=200", popped); end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d want=0", q.size()); end
    ready = 1'b0;
  endtask

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  task automatic test_almost_empty;
    do_reset;
    #1;
    total++; if (ae !== 1'b1) begin bad++; $display("FAIL ae_level0 got=%b want=1", ae); end
    tick;
    push(32'h1);
    tick;
    push(32'h2);
    #1;
    total++; if (ae !== 1'b1) begin bad++; $display("FAIL ae_level2 got=%b want=1", ae); end
    tick;
    push(32'h3);
    #1;
    total++; if (ae !== 1'b0) begin bad++; $display("FAIL ae_level3 got=%b want=0", ae); end
  endtask
`endif

  task automatic test_async_reset;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      push(32'h77 + 32'(i));
      tick;
    end
    #3;
    rst_n = 1'b0;
    wr_ptr = '0;
    #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", valid); end
    total++; if (data !== 32'd0) begin bad++; $display("FAIL arst_data got=%h want=0", data); end
    total++; if (rd_ptr !== 5'd0) begin bad++; $display("FAIL arst_rd_ptr got=%0d want=0", rd_ptr); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL arst_empty got=%b want=1", empty); end
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    total++; if (ae !== 1'b1) begin bad++; $display("FAIL arst_ae got=%b want=1", ae); end
`endif
    tick;
    rst_n = 1'b1;
    ready = 1'b1;
    tick;
    tick;
    total++; if (valid !== 1'b0 || empty !== 1'b1) begin
      bad++; $display("FAIL arst_after got valid=%b empty=%b want valid=0 empty=1", valid, empty);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill;
    test_stream;
    test_random;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    test_almost_empty;
`endif
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Single-clock read-side controller for the team's FIFO memory: it owns the read pointer, drives the memory read address, pulls words out of the asynchronous read port and presents them on a registered valid/ready stream. It sits between the memory's read port and the downstream consumer, and returns its read pointer to the write-side controller for full detection. A 2-entry output buffer sustains one word per cycle with registered outputs.

## Interface
- DW, 32, data width; must match the memory.
- AW, 4, address width; memory depth is 2^AW words.
- AE_THRESH, 2, almost-empty threshold in words; used only when FIFO_RD_ALMOST_EMPTY_EN is defined.

- I_CLK  in  1  clock; all state updates on its rising edge.
- I_RST_N  in  1  asynchronous active-low reset.
- I_WR_PTR  in  AW+1  write pointer, binary with wrap bit, from the write controller in the same clock domain.
- O_RD_PTR  out  AW+1  registered read pointer, binary with wrap bit, to the write controller.
- O_RD_ADDR  out  AW  memory read address, equal to O_RD_PTR[AW-1:0].
- I_RD_DATA  in  DW  memory read data, combinational from O_RD_ADDR.
- O_VALID  out  1  O_DATA holds a word.
- I_READY  in  1  consumer accepts O_DATA this cycle.
- O_DATA  out  DW  head word, registered.
- O_EMPTY  out  1  no word in memory and none buffered.
- O_ALMOST_EMPTY  out  1  present only with FIFO_RD_ALMOST_EMPTY_EN.

## Operation
- Memory level L = (I_WR_PTR - O_RD_PTR) mod 2^(AW+1); legal range 0..2^AW. L > 2^AW is a write-side protocol violation; behaviour then is unspecified but must not lock up after reset.
- Memory empty: L == 0 (all AW+1 bits equal).
- Buffer occupancy state: B0 (0 words), B1 (1, head only), B2 (2, head + skid).
- pop = O_VALID & I_READY. fetch = (L != 0) & (state != B2 | pop).
- On fetch: I_RD_DATA is captured, O_RD_PTR increments by 1 (wraps mod 2^(AW+1), flipping the wrap bit on address wrap).
- Transitions: next occupancy = occupancy + fetch - pop. B0->B1 on fetch; B1->B0 on pop only; B1->B2 on fetch only; B1 stays on fetch+pop; B2->B1 on pop without fetch; B2 stays on fetch+pop.
- Ordering: head always holds the oldest word. On pop with skid full, skid moves to head and a simultaneous fetch goes to skid. In B0/B1-with-pop, fetched word goes to head.
- O_VALID = (state != B0). O_DATA unchanged while O_VALID & ~I_READY.
- O_EMPTY = (state == B0) & (L == 0).
- Reset (any time, including mid-transfer): O_RD_PTR = 0, state B0, O_VALID = 0, O_DATA = 0, O_EMPTY = 1 when I_WR_PTR = 0; buffered words are discarded. Write side is reset together.

## Timing
- I_WR_PTR must advance on the same edge that writes the memory.
- Latency: word whose write advances I_WR_PTR at edge t is on O_DATA with O_VALID = 1 after edge t+1 (memory and buffer empty beforehand).
- Throughput: 1 word/cycle with I_READY held high.
- O_RD_PTR advances at the fetch edge; memory slot is free for writing from the next cycle.
- O_VALID, O_DATA, O_RD_PTR, O_RD_ADDR are register outputs; I_READY reaches only next-state logic.

## Configuration
- FIFO_RD_ALMOST_EMPTY_EN defined: O_ALMOST_EMPTY port exists, = (L + occupancy) <= AE_THRESH, combinational from registered state and I_WR_PTR; 1 after reset.
- Undefined: port and AE_THRESH logic absent; all other behaviour identical.

## Structure
- Shared package fifo_pkg: occupancy state encoding (B0/B1/B2), pointer-width constant AW+1, level-computation function.
- One sub-module: fifo_rd_skid, the 2-entry head/skid buffer (inputs fetch, fetch data, I_READY; outputs O_VALID, O_DATA, state). Pointer and level logic stay in fifo_rd_ctrl.

## Test plan
- Reset with I_WR_PTR = 0 -> O_VALID = 0, O_EMPTY = 1, O_RD_PTR = 0, O_DATA = 0.
- Write 0xA5 at addr 0, I_WR_PTR 0->1 at edge t, I_READY = 1 -> O_VALID = 1, O_DATA = 0xA5 after edge t+1; O_RD_PTR = 1; O_EMPTY = 1 the cycle after pop.
- Fill 16 words (AW = 4) 0..15, I_READY = 0 -> state B2, O_RD_PTR = 2, O_DATA = 0 stable; then I_READY = 1 -> 0..15 in order, one per cycle.
- Stream 40 words continuously with I_READY high -> no gaps after first, O_RD_PTR wrap bit toggles at 16 and 32, data in order.
- Random I_READY toggling, 200 words -> no loss, duplication or reordering; O_DATA stable while stalled.
- FIFO_RD_ALMOST_EMPTY_EN, AE_THRESH = 2: levels 0,2,3 -> O_ALMOST_EMPTY 1,1,0; assert I_RST_N low mid-stream -> all outputs at reset values immediately.
